tinyml_apb3_csr_bank: RTL and testbench

Parametrised APB3 control/status register slave for the TinyML vision subsystem. It sits between the RISC-V APB3 bridge and the camera, DMA, display and accelerator datapaths. It offers N read/write control registers, M read-only status registers, a fixed ID register, per-register self-clearing (pulse) control registers, programmable wait states and real PSLVERROR decoding. An optional sticky interrupt block is compiled in by a macro.

---
 rtl/tinyml_apb3_csr_bank.sv | 223 ++++++++++++++++++++++
 tb/tb_tinyml_apb3_csr_bank.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinyml_apb3_csr_bank.sv
// tinyml_apb3_csr_bank
// APB3 control/status register slave for the TinyML vision subsystem.
// Word map (k = PADDR[ADDR_WIDTH-1:2]):
//   0 .. NUM_CTRL-1                 control registers (RW, optional self-clear)
//   NUM_CTRL .. NUM_CTRL+NUM_STAT-1 status registers (RO, sampled in setup)
//   NUM_CTRL+NUM_STAT               ID register (RO)
//   +1 / +2                         IRQ_PEND (W1C) / IRQ_MASK (RW), only when
//                                   APB3_CSR_IRQ_EN is defined
// Unmapped words, misaligned addresses and writes to RO words raise PSLVERROR.
//
// FSM states:
//   state     | meaning
//   ST_IDLE   | no transfer in flight; a setup cycle (PSEL & !PENABLE) seen
//             | here is the SETUP phase: decode and latch PRDATA/PSLVERROR
//   ST_ACCESS | access phase; wait counter runs until PREADY

module tinyml_apb3_csr_bank #(
  parameter int                      ADDR_WIDTH      = 12,
  parameter int                      DATA_WIDTH      = 32,
  parameter int                      NUM_CTRL        = 8,
  parameter int                      NUM_STAT        = 10,
  parameter logic [NUM_CTRL-1:0]     SELF_CLEAR_MASK = '0,
  parameter int                      WAIT_STATES     = 0,
  parameter logic [DATA_WIDTH-1:0]   ID_VALUE        = 32'hABCD_5678,
  parameter int                      NUM_IRQ         = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  output logic                           PREADY,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PSLVERROR,
  output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_out,
  output logic [NUM_CTRL-1:0]            ctrl_wr_stb,
  input  logic [NUM_STAT*DATA_WIDTH-1:0] stat_in
`ifdef APB3_CSR_IRQ_EN
  ,
  input  logic [NUM_IRQ-1:0]             irq_event,
  output logic                           irq
`endif
);

  localparam logic [31:0] CTRL_END = 32'(NUM_CTRL);
  localparam logic [31:0] ID_IDX   = 32'(NUM_CTRL + NUM_STAT);
  localparam logic [2:0]  WS       = 3'(WAIT_STATES);
`ifdef APB3_CSR_IRQ_EN
  localparam logic [31:0] PEND_IDX = ID_IDX + 32'd1;
  localparam logic [31:0] MASK_IDX = ID_IDX + 32'd2;
`endif

  // Elaboration-time parameter range checks
  if (ADDR_WIDTH < 8 || ADDR_WIDTH > 34) begin : g_chk_aw
    $error("ADDR_WIDTH out of range");
  end
  if (NUM_CTRL < 1 || NUM_CTRL > 32 || NUM_STAT < 1 || NUM_STAT > 32) begin : g_chk_num
    $error("NUM_CTRL/NUM_STAT out of range");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 7) begin : g_chk_ws
    $error("WAIT_STATES out of range");
  end
  if (NUM_IRQ < 1 || NUM_IRQ > DATA_WIDTH) begin : g_chk_irq
    $error("NUM_IRQ out of range");
  end

  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

  state_t                state_q, state_d;
  logic [2:0]            wcnt_q, wcnt_d;
  logic                  setup_seen;
  logic                  commit;
  logic [31:0]           k_w;
  logic                  dec_err;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  pslverr_q;
  logic [DATA_WIDTH-1:0] ctrl_q [NUM_CTRL];
  logic [DATA_WIDTH-1:0] ctrl_d [NUM_CTRL];
  logic [NUM_CTRL-1:0]   stb_q, stb_d;

`ifdef APB3_CSR_IRQ_EN
  logic [NUM_IRQ-1:0]    pend_q, pend_d, mask_q, mask_d, w1c;
  logic                  irq_q;
`endif

  assign k_w       = 32'(PADDR[ADDR_WIDTH-1:2]);
  assign PREADY    = (state_q == ST_ACCESS) && (wcnt_q == WS);
  assign commit    = PREADY && PSEL && PENABLE && PWRITE && !pslverr_q;
  assign PRDATA    = prdata_q;
  assign PSLVERROR = pslverr_q;
  assign ctrl_wr_stb = stb_q;

  for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl_out
    assign ctrl_out[gi*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[gi];
  end

  // Address decode: read data mux and error classification
  always_comb begin
    rdata   = '0;
    dec_err = 1'b0;
    if (PADDR[1:0] != 2'b00) begin
      dec_err = 1'b1;
    end else if (k_w < CTRL_END) begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (k_w == 32'(i)) rdata = ctrl_q[i];
      end
    end else if (k_w < ID_IDX) begin
      dec_err = PWRITE;
      for (int j = 0; j < NUM_STAT; j++) begin
        if (k_w == CTRL_END + 32'(j)) rdata = stat_in[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (k_w == ID_IDX) begin
      dec_err = PWRITE;
      rdata   = ID_VALUE;
`ifdef APB3_CSR_IRQ_EN
    end else if (k_w == PEND_IDX) begin
      rdata[NUM_IRQ-1:0] = pend_q;
    end else if (k_w == MASK_IDX) begin
      rdata[NUM_IRQ-1:0] = mask_q;
`endif
    end else begin
      dec_err = 1'b1;
    end
  end

  // Transfer FSM next state and wait counter
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    setup_seen = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          setup_seen = 1'b1;
          state_d    = ST_ACCESS;
          wcnt_d     = '0;
        end
      end
      ST_ACCESS: begin
        if (!PSEL || PREADY) begin
          state_d = ST_IDLE;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  // Control register next values; self-clearing registers fall back to 0
  always_comb begin
    for (int i = 0; i < NUM_CTRL; i++) begin
      ctrl_d[i] = SELF_CLEAR_MASK[i] ? '0 : ctrl_q[i];
      stb_d[i]  = 1'b0;
      if (commit && (k_w == 32'(i))) begin
        ctrl_d[i] = PWDATA;
        stb_d[i]  = 1'b1;
      end
    end
  end

  // FSM, wait counter and latched read response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (setup_seen) begin
        prdata_q  <= dec_err ? '0 : rdata;
        pslverr_q <= dec_err;
      end
    end
  end

  // Control registers and write strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= '0;
      stb_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= ctrl_d[i];
      stb_q <= stb_d;
    end
  end

`ifdef APB3_CSR_IRQ_EN
  // Pending/mask next values; a new event wins over a same-cycle clear
  always_comb begin
    w1c    = '0;
    mask_d = mask_q;
    if (commit && (k_w == PEND_IDX)) w1c    = PWDATA[NUM_IRQ-1:0];
    if (commit && (k_w == MASK_IDX)) mask_d = PWDATA[NUM_IRQ-1:0];
    pend_d = (pend_q & ~w1c) | irq_event;
  end

  // Sticky interrupt state and registered interrupt output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
      irq_q  <= |(pend_q & mask_q);
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_tinyml_apb3_csr_bank.sv
// Bench for tinyml_apb3_csr_bank: directed scenarios plus randomized APB
// traffic compared against a word-level register map model.
module tb_tinyml_apb3_csr_bank;
  localparam int AW = 12, DW = 32, NC = 8, NS = 10, WS = 3, NI = 8;
  localparam logic [NC-1:0] SC  = 8'h04;
  localparam logic [31:0]   IDV = 32'hABCD_5678;
  localparam int ID_K = NC + NS;

  logic clk = 0, reset = 1;
  logic [AW-1:0] PADDR = '0;
  logic PSEL = 0, PENABLE = 0, PWRITE = 0;
  logic [DW-1:0] PWDATA = '0;
  logic PREADY, PSLVERROR;
  logic [DW-1:0] PRDATA;
  logic [NC*DW-1:0] ctrl_out;
  logic [NC-1:0] ctrl_wr_stb;
  logic [NS*DW-1:0] stat_in;
`ifdef APB3_CSR_IRQ_EN
  logic [NI-1:0] irq_event = '0;
  logic irq;
`endif

  logic [31:0] ctrl_m [NC];
  logic [31:0] stat_m [NS];
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int j = 0; j < NS; j++) stat_in[j*DW +: DW] = stat_m[j];
  end

  tinyml_apb3_csr_bank #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CTRL(NC), .NUM_STAT(NS),
    .SELF_CLEAR_MASK(SC), .WAIT_STATES(WS), .ID_VALUE(IDV), .NUM_IRQ(NI)
  ) dut (
    .clk(clk), .reset(reset), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA),
    .PSLVERROR(PSLVERROR), .ctrl_out(ctrl_out), .ctrl_wr_stb(ctrl_wr_stb),
    .stat_in(stat_in)
`ifdef APB3_CSR_IRQ_EN
    , .irq_event(irq_event), .irq(irq)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected response of the register map for one access, before it happens
  function automatic void model_expect(input int k, input logic [1:0] lo, input bit wr,
                                       output bit err, output logic [31:0] data);
    err = 0; data = '0;
    if (lo != 2'b00) err = 1;
    else if (k < NC) data = ctrl_m[k];
    else if (k < NC + NS) begin err = wr; data = stat_m[k-NC]; end
    else if (k == ID_K) begin err = wr; data = IDV; end
`ifdef APB3_CSR_IRQ_EN
    else if (k == ID_K + 1 || k == ID_K + 2) err = 0;
`endif
    else err = 1;
    if (err) data = '0;
  endfunction

  task automatic apb(input logic [AW-1:0] addr, input bit wr, input logic [31:0] wd,
                     output logic [31:0] rd, output bit err, output int waits);
    @(posedge clk); #1;
    PADDR = addr; PWRITE = wr; PWDATA = wd; PSEL = 1; PENABLE = 0;
    @(posedge clk); #1;
    PENABLE = 1;
    waits = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      waits++;
      if (PREADY) break;
    end
    if (!PREADY) check("pready_timeout", 32'(waits), 32'(WS + 1));
    rd = PRDATA; err = PSLVERROR;
    @(posedge clk); #1;
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic check_all_ctrl(input string tag);
    for (int i = 0; i < NC; i++)
      check($sformatf("%s_ctrl%0d", tag, i), ctrl_out[i*DW +: DW], ctrl_m[i]);
  endtask

  initial begin
    #800us;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, wd, exp_d;
    bit err, exp_e, wr;
    int waits, k;
    logic [1:0] lo;

    for (int i = 0; i < NC; i++) ctrl_m[i] = '0;
    for (int j = 0; j < NS; j++) stat_m[j] = $urandom;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pready", PREADY, 0);
    check("rst_prdata", PRDATA, 0);
    check("rst_pslverr", PSLVERROR, 0);
    check("rst_stb", ctrl_wr_stb, 0);
    check_all_ctrl("rst");
`ifdef APB3_CSR_IRQ_EN
    check("rst_irq", irq, 0);
`endif
    reset = 0;

    // Plain write and readback of control register 0
    apb(12'h000, 1, 32'h1234_5678, rd, err, waits);
    check("wr0_err", err, 0);
    check("wr0_waits", 32'(waits), 32'(WS + 1));
    @(negedge clk);
    check("wr0_stb", ctrl_wr_stb, 8'h01);
    check("wr0_ctrl", ctrl_out[0 +: DW], 32'h1234_5678);
    @(negedge clk);
    check("wr0_stb_end", ctrl_wr_stb, 8'h00);
    ctrl_m[0] = 32'h1234_5678;
    apb(12'h000, 0, 0, rd, err, waits);
    check("rd0_data", rd, 32'h1234_5678);
    check("rd0_err", err, 0);

    // Self-clearing register 2
    apb(12'h008, 1, 32'h3, rd, err, waits);
    @(negedge clk);
    check("sc2_pulse", ctrl_out[2*DW +: DW], 32'h3);
    check("sc2_stb", ctrl_wr_stb, 8'h04);
    @(negedge clk);
    check("sc2_clear", ctrl_out[2*DW +: DW], 32'h0);
    apb(12'h008, 0, 0, rd, err, waits);
    check("sc2_read", rd, 32'h0);

    // ID register and error cases
    apb(12'(ID_K * 4), 0, 0, rd, err, waits);
    check("id_data", rd, IDV);
    check("id_err", err, 0);
    apb(12'((NC + 1) * 4), 1, 32'hDEAD_BEEF, rd, err, waits);
    check("wr_stat_err", err, 1);
    check("wr_stat_data", rd, 0);
    apb(12'h002, 1, 32'hFFFF_0000, rd, err, waits);
    check("misalign_err", err, 1);
    @(negedge clk);
    check("misalign_stb", ctrl_wr_stb, 0);
    check_all_ctrl("after_err");
`ifndef APB3_CSR_IRQ_EN
    apb(12'((ID_K + 1) * 4), 0, 0, rd, err, waits);
    check("noirq_pend_err", err, 1);
    apb(12'((ID_K + 2) * 4), 1, 32'h1, rd, err, waits);
    check("noirq_mask_err", err, 1);
`endif

    // PSEL dropped in the second access cycle: no write
    @(posedge clk); #1;
    PADDR = 12'h014; PWRITE = 1; PWDATA = 32'h5555_AAAA; PSEL = 1; PENABLE = 0;
    @(posedge clk); #1;
    PENABLE = 1;
    @(negedge clk);
    check("abort_pready", PREADY, 0);
    @(posedge clk); #1;
    PSEL = 0; PENABLE = 0; PWRITE = 0;
    repeat (2) @(negedge clk);
    check("abort_stb", ctrl_wr_stb, 0);
    check("abort_ctrl5", ctrl_out[5*DW +: DW], ctrl_m[5]);
    apb(12'h014, 0, 0, rd, err, waits);
    check("abort_rd5", rd, ctrl_m[5]);
    check("abort_waits", 32'(waits), 32'(WS + 1));

    // Randomized traffic against the map model
    for (int it = 0; it < 80; it++) begin
      for (int j = 0; j < NS; j++) stat_m[j] = $urandom;
      k  = $urandom_range(0, ID_K + 1);
      if (k == ID_K + 1) k = ID_K + 3;
      lo = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      model_expect(k, lo, wr, exp_e, exp_d);
      apb({10'(k), lo}, wr, wd, rd, err, waits);
      check("rnd_err", err, exp_e);
      check("rnd_waits", 32'(waits), 32'(WS + 1));
      if (!wr) check("rnd_rdata", rd, exp_d);
      @(negedge clk);
      if (wr && !exp_e && k < NC) begin
        check("rnd_stb", ctrl_wr_stb, 32'(1) << k);
        check("rnd_wval", ctrl_out[k*DW +: DW], wd);
        ctrl_m[k] = SC[k] ? 32'h0 : wd;
      end else begin
        check("rnd_nostb", ctrl_wr_stb, 0);
      end
      @(negedge clk);
      check_all_ctrl("rnd");
    end

`ifdef APB3_CSR_IRQ_EN
    // Interrupt path
    apb(12'((ID_K + 2) * 4), 1, 32'h2, rd, err, waits);
    check("mask_wr_err", err, 0);
    @(posedge clk); #1 irq_event = 8'h02;
    @(posedge clk); #1 irq_event = 8'h00;
    @(negedge clk);
    check("irq_lat1", irq, 0);
    @(negedge clk);
    check("irq_lat2", irq, 1);
    apb(12'((ID_K + 1) * 4), 0, 0, rd, err, waits);
    check("pend_rd", rd, 32'h2);
    irq_event = 8'h02;
    apb(12'((ID_K + 1) * 4), 1, 32'h2, rd, err, waits);
    apb(12'((ID_K + 1) * 4), 0, 0, rd, err, waits);
    check("pend_held", rd, 32'h2);
    check("irq_held", irq, 1);
    irq_event = 8'h00;
    apb(12'((ID_K + 1) * 4), 1, 32'h2, rd, err, waits);
    apb(12'((ID_K + 1) * 4), 0, 0, rd, err, waits);
    check("pend_clr", rd, 32'h0);
    check("irq_clr", irq, 0);
    @(posedge clk); #1 irq_event = 8'h01;
    @(posedge clk); #1 irq_event = 8'h00;
    repeat (3) @(negedge clk);
    check("irq_masked", irq, 0);
    apb(12'((ID_K + 2) * 4), 0, 0, rd, err, waits);
    check("mask_rd", rd, 32'h2);
`endif

    // Reset during the access phase of a write to register 1
    apb(12'h004, 1, 32'hCAFE_0001, rd, err, waits);
    ctrl_m[1] = 32'hCAFE_0001;
    @(negedge clk);
    check("pre_rst_ctrl1", ctrl_out[1*DW +: DW], 32'hCAFE_0001);
    @(posedge clk); #1;
    PADDR = 12'h004; PWRITE = 1; PWDATA = 32'h0000_0055; PSEL = 1; PENABLE = 0;
    @(posedge clk); #1;
    PENABLE = 1;
    @(negedge clk);
    reset = 1;
    #1;
    check("midrst_ctrl1", ctrl_out[1*DW +: DW], 32'h0);
    check("midrst_pready", PREADY, 0);
    check("midrst_stb", ctrl_wr_stb, 0);
    @(posedge clk); #1;
    PSEL = 0; PENABLE = 0; PWRITE = 0;
    reset = 0;
    for (int i = 0; i < NC; i++) ctrl_m[i] = '0;
    @(negedge clk);
    check_all_ctrl("postrst");
    apb(12'h004, 0, 0, rd, err, waits);
    check("postrst_rd1", rd, 32'h0);
    check("postrst_waits", 32'(waits), 32'(WS + 1));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
